// File: rtl/kronos_pkg.sv
// Shared Kronos pipeline types: IF->ID packet and fetch FSM state encoding.
package kronos_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;

    localparam logic [1:0] FETCH_INIT  = 2'd0;
    localparam logic [1:0] FETCH_FETCH = 2'd1;
    localparam logic [1:0] FETCH_DRAIN = 2'd2;

endpackage

// File: rtl/kronos_skid_buf.sv
// Two-entry valid/ready skid buffer for pipeIFID_t: output register plus one skid slot.
module kronos_skid_buf
    import kronos_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [63:0] in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [63:0] out_data,
    output logic        out_vld,
    input  logic        out_rdy
);

    pipeIFID_t skid_data;
    logic      skid_vld;
    logic      push, pop;

    // Upstream may only push while the skid slot is free, so a push always has a home.
    assign in_rdy = !skid_vld;
    assign push   = in_vld && in_rdy;
    assign pop    = !out_vld || out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_vld   <= 1'b0;
            skid_data <= '0;
            skid_vld  <= 1'b0;
        end else if (flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (pop) begin
            if (skid_vld) begin
                out_data <= skid_data;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                out_vld <= push;
                if (push) out_data <= in_data;
            end
        end else if (push) begin
            skid_data <= in_data;
            skid_vld  <= 1'b1;
        end
    end

endmodule

// File: rtl/kronos_fetch.sv
// Kronos RV32I fetch stage: single-outstanding instruction bus master with PC sequencing and redirect drain.
module kronos_fetch
    import kronos_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic [63:0] fetch,
    output logic        fetch_vld,
    input  logic        fetch_rdy
);

    logic [1:0]  state;
    logic [31:0] pc, target, br_pc;
    logic        buf_rdy, word_vld;
    pipeIFID_t   word;

    assign br_pc      = branch_target & ~32'h3;
    assign instr_addr = pc;

    // pc is the address of the outstanding request; it only advances on ack, which keeps the bus stable.
    always_comb begin
        instr_req = 1'b0;
        case (state)
            FETCH_FETCH: instr_req = buf_rdy;
            FETCH_DRAIN: instr_req = 1'b1;
            default:     instr_req = 1'b0;
        endcase
    end

    assign word_vld = (state == FETCH_FETCH) && instr_req && instr_ack;
    assign word     = '{pc: pc, ir: instr_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH_INIT;
            pc     <= BOOT_ADDR;
            target <= BOOT_ADDR;
        end else begin
            case (state)
                FETCH_INIT: begin
                    state <= FETCH_FETCH;
                    if (branch) pc <= br_pc;
                end
                FETCH_FETCH: begin
                    if (branch) begin
                        if (instr_req && !instr_ack) begin
                            target <= br_pc;
                            state  <= FETCH_DRAIN;
                        end else begin
                            pc <= br_pc;
                        end
                    end else if (instr_req && instr_ack) begin
                        pc <= pc + 32'd4;
                    end
                end
                FETCH_DRAIN: begin
                    // The stale word is dropped; the newest redirect wins if it lands with the ack.
                    if (instr_ack) begin
                        pc    <= branch ? br_pc : target;
                        state <= FETCH_FETCH;
                    end else if (branch) begin
                        target <= br_pc;
                    end
                end
                default: state <= FETCH_INIT;
            endcase
        end
    end

    kronos_skid_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (branch),
        .in_data  (word),
        .in_vld   (word_vld),
        .in_rdy   (buf_rdy),
        .out_data (fetch),
        .out_vld  (fetch_vld),
        .out_rdy  (fetch_rdy)
    );

endmodule

// File: tb/tb_kronos_fetch.sv
// Bench for kronos_fetch: vector table, directed redirect/wrap/reset sequences and a randomized run vs a stream model.
module tb_kronos_fetch;

    localparam logic [31:0] BOOT = 32'h100;

    logic        clk, rst;
    logic [31:0] instr_addr, instr_data, branch_target;
    logic        instr_req, instr_ack, branch, fetch_vld, fetch_rdy;
    logic [63:0] fetch;

    kronos_fetch #(.BOOT_ADDR(BOOT)) dut (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(instr_data), .instr_ack(instr_ack), .branch(branch),
        .branch_target(branch_target), .fetch(fetch), .fetch_vld(fetch_vld),
        .fetch_rdy(fetch_rdy)
    );

    int n_chk = 0, n_fail = 0, n_cons = 0;
    int lat = 0, lat_r = 0, wcnt = 0;
    logic rnd = 0, force_ack = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory-like bus: ack once the request has waited the chosen number of cycles.
    always @(posedge clk) begin
        #1;
        instr_ack  = force_ack || (instr_req && wcnt >= (rnd ? lat_r : lat));
        instr_data = mem(instr_addr);
    end

    // Reference model: delivered words must form the sequential stream restarted at each redirect.
    logic [31:0] exp_pc = BOOT, pend_addr = '0;
    logic [63:0] prev_fetch = '0;
    logic        pend = 0, stall = 0;
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = BOOT; pend = 0; stall = 0; wcnt = 0;
        end else begin
            if (pend) begin
                chk("bus_hold_req", instr_req, 1'b1);
                chk("bus_hold_addr", instr_addr, pend_addr);
            end
            if (stall) begin
                chk("hold_vld", fetch_vld, 1'b1);
                chk("hold_payload", fetch, prev_fetch);
            end
            if (instr_req) chk("addr_align", instr_addr[1:0], 2'b00);
            if (fetch_vld && fetch_rdy) begin
                chk("stream_pc", fetch[63:32], exp_pc);
                chk("stream_ir", fetch[31:0], mem(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
            if (branch) exp_pc = {branch_target[31:2], 2'b00};
            pend       = instr_req && !instr_ack;
            pend_addr  = instr_addr;
            stall      = fetch_vld && !fetch_rdy && !branch;
            prev_fetch = fetch;
            if (instr_req && !instr_ack) wcnt++;
            else wcnt = 0;
            if (instr_req && instr_ack) lat_r = $urandom_range(0, 3);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rst_req", instr_req, 1'b0);
        chk("rst_vld", fetch_vld, 1'b0);
        chk("rst_fetch", fetch, 64'h0);
        chk("rst_addr", instr_addr, BOOT);
        next_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rs;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;
    vec_t tab[13];

    initial begin
        rst = 1'b1; branch = 1'b0; branch_target = '0; fetch_rdy = 1'b1;
        instr_ack = 1'b0; instr_data = '0;

        // Zero-wait streaming, then a 5-cycle decode stall and release.
        tab[0]  = '{1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
        tab[1]  = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        tab[2]  = '{1'b0, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100};
        tab[3]  = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        tab[4]  = '{1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h108};
        tab[5]  = '{1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0};
        tab[6]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
        tab[7]  = '{1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'h100};
        tab[8]  = '{1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tab[10] = '{1'b0, 1'b1, 1'b0, 32'h108, 1'b1, 32'h100};
        tab[11] = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        tab[12] = '{1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h108};

        for (int i = 0; i < 13; i++) begin
            if (tab[i].rs) do_reset();
            else next_cycle();
            fetch_rdy = tab[i].rdy;
            chk($sformatf("vec%0d_req", i), instr_req, tab[i].req);
            chk($sformatf("vec%0d_addr", i), instr_addr, tab[i].addr);
            chk($sformatf("vec%0d_vld", i), fetch_vld, tab[i].vld);
            if (tab[i].vld) begin
                chk($sformatf("vec%0d_pc", i), fetch[63:32], tab[i].pc);
                chk($sformatf("vec%0d_ir", i), fetch[31:0], mem(tab[i].pc));
            end
        end

        // Redirect on the second wait cycle of a 3-cycle bus: drain the stale fetch.
        fetch_rdy = 1'b1; lat = 2;
        do_reset();
        next_cycle();
        next_cycle();
        chk("drain_pre_addr", instr_addr, 32'h100);
        branch = 1'b1; branch_target = 32'h200;
        next_cycle();
        branch = 1'b0;
        chk("drain_req", instr_req, 1'b1);
        chk("drain_stale_addr", instr_addr, 32'h100);
        chk("drain_vld", fetch_vld, 1'b0);
        next_cycle();
        chk("drain_next_addr", instr_addr, 32'h200);
        chk("drain_next_vld", fetch_vld, 1'b0);
        begin
            int k = 0;
            while (!fetch_vld && k < 10) begin next_cycle(); k++; end
            chk("drain_timeout", k < 10, 1'b1);
            chk("drain_first_pc", fetch[63:32], 32'h200);
        end

        // Redirect to a misaligned target coinciding with an ack, then PC wrap.
        lat = 0;
        do_reset();
        next_cycle();
        next_cycle();
        next_cycle();
        chk("bra_ack_addr", instr_addr, 32'h108);
        chk("bra_ack_ack", instr_ack, 1'b1);
        branch = 1'b1; branch_target = 32'h203;
        next_cycle();
        branch = 1'b0;
        chk("bra_ack_vld", fetch_vld, 1'b0);
        chk("bra_ack_addr2", instr_addr, 32'h200);
        next_cycle();
        chk("bra_ack_pc", fetch[63:32], 32'h200);
        branch = 1'b1; branch_target = 32'hFFFF_FFFC;
        next_cycle();
        branch = 1'b0;
        chk("wrap_addr0", instr_addr, 32'hFFFF_FFFC);
        next_cycle();
        chk("wrap_addr1", instr_addr, 32'h0);
        chk("wrap_vld", fetch_vld, 1'b1);
        chk("wrap_pc", fetch[63:32], 32'hFFFF_FFFC);
        chk("wrap_ir", fetch[31:0], mem(32'hFFFF_FFFC));
        next_cycle();
        chk("wrap_next_pc", fetch[63:32], 32'h0);

        // Reset mid-transaction, then a late ack during INIT must be ignored.
        chk("mid_pre_req", instr_req, 1'b1);
        chk("mid_pre_vld", fetch_vld, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", instr_req, 1'b0);
        chk("mid_rst_vld", fetch_vld, 1'b0);
        chk("mid_rst_fetch", fetch, 64'h0);
        force_ack = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("init_ack_seen", instr_ack, 1'b1);
        chk("init_req", instr_req, 1'b0);
        force_ack = 1'b0;
        next_cycle();
        chk("init_next_req", instr_req, 1'b1);
        chk("init_next_addr", instr_addr, BOOT);
        chk("init_next_vld", fetch_vld, 1'b0);
        next_cycle();
        chk("init_first_vld", fetch_vld, 1'b1);
        chk("init_first_pc", fetch[63:32], BOOT);

        // Random latency, back-pressure, redirects and occasional resets.
        rnd = 1'b1;
        n_cons = 0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst           = ($urandom_range(0, 399) == 0);
            fetch_rdy     = ($urandom_range(0, 9) < 7);
            branch        = ($urandom_range(0, 19) == 0);
            branch_target = $urandom;
        end
        next_cycle();
        rst = 1'b0; branch = 1'b0;
        chk("random_progress", n_cons > 200, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/kronos_fetch.md
# kronos_fetch

Instruction fetch stage of the Kronos RV32I core. It drives the instruction bus, holds a single outstanding request and sequences the PC. Fetched words are presented to decode as a `pipeIFID_t` packet over a valid/ready handshake. Branch/jump redirects from the execute/write-back side flush any instruction buffered in this stage, and any fetch already in flight on the bus is drained.

## Interface
- `BOOT_ADDR`, default 32'h0: PC of the first fetch after reset.

- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `instr_addr`  out  32  bus address, word-aligned.
- `instr_req`  out  1  bus request.
- `instr_data`  in  32  read data, valid when `instr_ack`=1.
- `instr_ack`  in  1  bus acknowledge; may assert in the same cycle as `instr_req`.
- `branch`  in  1  single-cycle redirect strobe.
- `branch_target`  in  32  redirect PC, sampled when `branch`=1.
- `fetch`  out  64  `pipeIFID_t` {pc, ir} to decode.
- `fetch_vld`  out  1  `fetch` is valid.
- `fetch_rdy`  in  1  decode accepts `fetch`.

## Operation
- FSM states:
  - INIT: reset state, lasts one cycle, `instr_req`=0. Always goes to FETCH.
  - FETCH: normal fetching.
  - DRAIN: a redirect happened while a bus request was outstanding; the stage waits for that request's ack and discards its data.
- Bus rule:
  - Once `instr_req`=1, both `instr_req` and `instr_addr` stay stable until the cycle with `instr_ack`=1.
  - `instr_req` never depends combinationally on `fetch_rdy`.
- Buffering: a 2-entry buffer made of the output register plus one skid entry.
  - In FETCH, `instr_req` = !skid_vld.
  - Because a request is only issued while the skid entry is empty, the acked word always has a slot.
- Ack in FETCH without `branch`:
  - The word goes to the output register if it is empty or being consumed this cycle; otherwise it goes to the skid entry.
  - pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Payload is {pc, ir} = {address of the request, `instr_data`}.
- Consume (`fetch_vld` && `fetch_rdy`): the skid entry, if valid, moves to the output register. Order is always preserved.
- `branch`=1 in any state (takes priority over everything else):
  - Output and skid entries are invalidated: `fetch_vld`=0 the next cycle.
  - Target is `{branch_target[31:2], 2'b00}`.
  - If `instr_req`=1 and `instr_ack`=0 this cycle: save the target, go to DRAIN.
  - Otherwise (no request, or ack in the same cycle, whose data is discarded): pc <= target, stay in or enter FETCH.
- DRAIN:
  - `instr_req`=1 at the stale address; nothing is written to the buffer.
  - On ack: pc <= saved target, go to FETCH.
  - A further `branch` while in DRAIN overwrites the saved target; the FSM stays in DRAIN (and if it coincides with the ack, FETCH resumes at the newest target).
- Payload stability: while `fetch_vld` && !`fetch_rdy`, `fetch` is held constant unless `branch` flushes it.

## Timing
- Reset values: state INIT, pc = `BOOT_ADDR`, `instr_req`=0, `instr_addr`=`BOOT_ADDR`, `fetch`=0, `fetch_vld`=0, skid empty.
- First request in the first cycle after reset release, at `BOOT_ADDR`.
- Latency: ack at cycle N gives `fetch_vld`=1 with that word at N+1.
- Throughput: with zero-wait ack and `fetch_rdy`=1, one instruction per cycle.
- With decode stalled, at most 2 words are buffered, after which `instr_req`=0.
- Redirect with no outstanding request: request to the target in cycle N+1.
- Redirect with an outstanding request: request to the target in the cycle after the drained ack.
- Reset asserted mid-transaction: all state clears immediately. A late ack while in INIT is ignored.

## Structure
- `pipeIFID_t` already lives in the shared types package.
- Add the fetch FSM state enum (INIT/FETCH/DRAIN) to that package.
- One sub-module: `kronos_skid_buf`, a 2-entry valid/ready skid buffer carrying `pipeIFID_t`. It is reusable between the ID and EX stages.

## Test plan
- Reset with `BOOT_ADDR`=32'h100 and zero-wait ack, `fetch_rdy`=1 -> `instr_addr` sequence 0x100, 0x104, 0x108; `fetch.pc` follows one cycle later; one instruction per cycle.
- Hold `fetch_rdy`=0 for 5 cycles -> exactly 2 words buffered, `instr_req`=0, `fetch` stable. After release, words are delivered in order 0x100 then 0x104, and fetching resumes at 0x108.
- Bus with 3-cycle ack latency, `branch` to 32'h200 on the second wait cycle -> `instr_addr` stays at the stale address until ack; that data never appears; next request is 0x200.
- `branch` to 32'h203 coinciding with ack -> acked word dropped, `fetch_vld`=0 the next cycle, next request is 0x200.
- PC at 32'hFFFF_FFFC, ack -> next `instr_addr`=0; the FFFF_FFFC word is delivered with the correct pc.
- Assert `rst` while `instr_req`=1 and `fetch_vld`=1 -> both drop immediately. After release there is one INIT cycle, then a request to `BOOT_ADDR`.
